// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the Bridge. Serialises m0 (CPU) and
// m1 (DMA/debug) accesses and holds each one on the bus for WAIT_CYCLES extra cycles.
module bus_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_wen,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_wen,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,

    output logic [31:0] Bus_addr,
    output logic        Bus_wen,
    output logic [31:0] Bus_wdata,
    input  logic [31:0] Bus_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] counter;
    logic       sel;
    logic       last_gnt;
    logic       grant_m1;

    // m1 wins when it is the only requester, or on contention when m0 was served last.
    assign grant_m1 = m1_req && (!m0_req || !last_gnt);

    assign busy = (state != IDLE);

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state     <= IDLE;
            counter   <= 4'd0;
            sel       <= 1'b0;
            last_gnt  <= 1'b1;
            Bus_addr  <= 32'd0;
            Bus_wdata <= 32'd0;
            Bus_wen   <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        sel       <= grant_m1;
                        Bus_addr  <= grant_m1 ? m1_addr  : m0_addr;
                        Bus_wdata <= grant_m1 ? m1_wdata : m0_wdata;
                        Bus_wen   <= grant_m1 ? m1_wen   : m0_wen;
                        counter   <= WAIT_LOAD;
                        state     <= BUSY;
                    end else begin
                        Bus_wen <= 1'b0;
                    end
                end

                BUSY: begin
                    // The write strobe only lives in the first BUSY cycle.
                    Bus_wen <= 1'b0;
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        if (sel) begin
                            m1_rdata <= Bus_rdata;
                        end else begin
                            m0_rdata <= Bus_rdata;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    if (sel) begin
                        m1_ack <= 1'b1;
                    end else begin
                        m0_ack <= 1'b1;
                    end
                    last_gnt <= sel;
                    state    <= IDLE;
                end

                default: begin
                    Bus_wen <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: one instance with WAIT_CYCLES=1
// and a second with WAIT_CYCLES=0 sharing clock and reset.
module tb_bus_arbiter;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b1;

    logic        m0_req = 1'b0, m0_wen = 1'b0, m1_req = 1'b0, m1_wen = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [31:0] Bus_rdata = '0;
    logic        m0_ack, m1_ack, Bus_wen, busy;
    logic [31:0] m0_rdata, m1_rdata, Bus_addr, Bus_wdata;

    logic        w_m0_req = 1'b0, w_m0_wen = 1'b0, w_m1_req = 1'b0, w_m1_wen = 1'b0;
    logic [31:0] w_m0_addr = '0, w_m0_wdata = '0, w_m1_addr = '0, w_m1_wdata = '0;
    logic [31:0] w_rdata = '0;
    logic        w_m0_ack, w_m1_ack, w_bus_wen, w_busy;
    logic [31:0] w_m0_rdata, w_m1_rdata, w_bus_addr, w_bus_wdata;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.WAIT_CYCLES(1)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata),
        .Bus_rdata(Bus_rdata), .busy(busy)
    );

    bus_arbiter #(.WAIT_CYCLES(0)) dut0 (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .m0_req(w_m0_req), .m0_addr(w_m0_addr), .m0_wen(w_m0_wen), .m0_wdata(w_m0_wdata),
        .m0_ack(w_m0_ack), .m0_rdata(w_m0_rdata),
        .m1_req(w_m1_req), .m1_addr(w_m1_addr), .m1_wen(w_m1_wen), .m1_wdata(w_m1_wdata),
        .m1_ack(w_m1_ack), .m1_rdata(w_m1_rdata),
        .Bus_addr(w_bus_addr), .Bus_wen(w_bus_wen), .Bus_wdata(w_bus_wdata),
        .Bus_rdata(w_rdata), .busy(w_busy)
    );

    initial forever #5 cpu_clk = ~cpu_clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        cpu_rst_n = 1'b0;
        tick();
        cpu_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cpu_rst_n = 1'b1;
        #1;
        cpu_rst_n = 1'b0;
        #1;
        checks++;
        if ({m0_ack, m1_ack, busy, Bus_wen} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {m0_ack, m1_ack, busy, Bus_wen});
        end
        checks++;
        if ({Bus_addr, Bus_wdata} !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got %h/%h expected 0/0", Bus_addr, Bus_wdata);
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata);
        end
        checks++;
        if ({w_m0_ack, w_m1_ack, w_busy, w_bus_wen} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_dut0: got %b expected 0000", {w_m0_ack, w_m1_ack, w_busy, w_bus_wen});
        end
        tick();
        tick();
        cpu_rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_single_read();
        logic exp_ack;
        Bus_rdata = 32'hDEAD_BEEF;
        m0_addr = 32'h0000_4000;
        m0_wen = 1'b0;
        m0_req = 1'b1;
        tick();
        checks++;
        if (Bus_addr !== 32'h0000_4000 || busy !== 1'b1 || Bus_wen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_grant: got addr=%h busy=%b wen=%b expected 00004000/1/0", Bus_addr, busy, Bus_wen);
        end
        for (int n = 1; n <= 6; n++) begin
            tick();
            exp_ack = (n == 3);
            checks++;
            if (m0_ack !== exp_ack || m1_ack !== 1'b0 || Bus_wen !== 1'b0) begin
                errors++;
                $display("[TB] FAIL read_cycle%0d: got m0_ack=%b m1_ack=%b wen=%b expected %b/0/0", n, m0_ack, m1_ack, Bus_wen, exp_ack);
            end
            if (n == 3) begin
                checks++;
                if (m0_rdata !== 32'hDEAD_BEEF || m1_rdata !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL read_data: got %h/%h expected deadbeef/00000000", m0_rdata, m1_rdata);
                end
                m0_req = 1'b0;
            end
        end
    endtask

    task automatic test_single_write();
        logic exp_ack;
        Bus_rdata = 32'hA5A5_A5A5;
        m1_addr = 32'hFFFF_F000;
        m1_wdata = 32'h1234_5678;
        m1_wen = 1'b1;
        m1_req = 1'b1;
        tick();
        checks++;
        if (Bus_wen !== 1'b1 || Bus_addr !== 32'hFFFF_F000 || Bus_wdata !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL write_strobe: got wen=%b addr=%h data=%h expected 1/fffff000/12345678", Bus_wen, Bus_addr, Bus_wdata);
        end
        for (int n = 1; n <= 5; n++) begin
            tick();
            exp_ack = (n == 3);
            checks++;
            if (m1_ack !== exp_ack || m0_ack !== 1'b0 || Bus_wen !== 1'b0) begin
                errors++;
                $display("[TB] FAIL write_cycle%0d: got m1_ack=%b m0_ack=%b wen=%b expected %b/0/0", n, m1_ack, m0_ack, Bus_wen, exp_ack);
            end
            if (n == 3) begin
                checks++;
                if (m0_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("[TB] FAIL write_m0_rdata: got %h expected deadbeef", m0_rdata);
                end
                m1_req = 1'b0;
                m1_wen = 1'b0;
            end
        end
    endtask

    task automatic test_contention();
        logic exp0, exp1;
        logic [31:0] exp_addr;
        do_reset();
        Bus_rdata = 32'h0BAD_F00D;
        m0_addr = 32'h0000_0100;
        m1_addr = 32'h0000_0200;
        m0_wen = 1'b0;
        m1_wen = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int n = 0; n <= 15; n++) begin
            tick();
            exp0 = (n == 3) || (n == 11);
            exp1 = (n == 7) || (n == 15);
            checks++;
            if (m0_ack !== exp0 || m1_ack !== exp1) begin
                errors++;
                $display("[TB] FAIL contention_ack%0d: got %b%b expected %b%b", n, m0_ack, m1_ack, exp0, exp1);
            end
            if (n % 4 == 0) begin
                exp_addr = (n % 8 == 0) ? 32'h0000_0100 : 32'h0000_0200;
                checks++;
                if (Bus_addr !== exp_addr) begin
                    errors++;
                    $display("[TB] FAIL contention_grant%0d: got %h expected %h", n, Bus_addr, exp_addr);
                end
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        checks++;
        if (m1_rdata !== 32'h0BAD_F00D || m0_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("[TB] FAIL contention_rdata: got %h/%h expected 0badf00d/0badf00d", m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_payload_change();
        logic exp_ack;
        m0_addr = 32'h0000_0010;
        m0_wen = 1'b0;
        m0_req = 1'b1;
        tick();
        m0_addr = 32'h0000_0020;
        for (int n = 1; n <= 4; n++) begin
            tick();
            exp_ack = (n == 3);
            checks++;
            if (Bus_addr !== 32'h0000_0010 || m0_ack !== exp_ack) begin
                errors++;
                $display("[TB] FAIL payload_hold%0d: got addr=%h ack=%b expected 00000010/%b", n, Bus_addr, m0_ack, exp_ack);
            end
            if (n == 3) m0_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_busy();
        logic exp_ack;
        m0_addr = 32'h0000_0300;
        m0_wdata = 32'h0000_0055;
        m0_wen = 1'b1;
        m0_req = 1'b1;
        tick();
        checks++;
        if (Bus_wen !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_start: got wen=%b busy=%b expected 1/1", Bus_wen, busy);
        end
        #3;
        cpu_rst_n = 1'b0;
        #1;
        checks++;
        if ({Bus_wen, busy, m0_ack, m1_ack} !== 4'b0000 || Bus_addr !== 32'd0 || Bus_wdata !== 32'd0
            || m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midreset_async: got wen=%b busy=%b addr=%h wdata=%h rd=%h/%h expected all 0",
                     Bus_wen, busy, Bus_addr, Bus_wdata, m0_rdata, m1_rdata);
        end
        m0_req = 1'b0;
        m0_wen = 1'b0;
        tick();
        cpu_rst_n = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            checks++;
            if (m0_ack !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_noack%0d: got ack=%b busy=%b expected 0/0", n, m0_ack, busy);
            end
        end
        Bus_rdata = 32'hDEAD_BEEF;
        m0_addr = 32'h0000_4000;
        m0_req = 1'b1;
        tick();
        for (int n = 1; n <= 4; n++) begin
            tick();
            exp_ack = (n == 3);
            checks++;
            if (m0_ack !== exp_ack) begin
                errors++;
                $display("[TB] FAIL postreset_ack%0d: got %b expected %b", n, m0_ack, exp_ack);
            end
            if (n == 3) begin
                checks++;
                if (m0_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("[TB] FAIL postreset_rdata: got %h expected deadbeef", m0_rdata);
                end
                m0_req = 1'b0;
            end
        end
    endtask

    task automatic test_req_withdrawn();
        logic exp_ack, exp_busy;
        int busy_cycles;
        // WAIT_CYCLES=1 instance: single-cycle request still completes.
        m1_addr = 32'h0000_0044;
        m1_req = 1'b1;
        tick();
        m1_req = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            exp_ack = (n == 3);
            checks++;
            if (m1_ack !== exp_ack || m0_ack !== 1'b0) begin
                errors++;
                $display("[TB] FAIL withdraw_w1_%0d: got m1_ack=%b m0_ack=%b expected %b/0", n, m1_ack, m0_ack, exp_ack);
            end
        end
        // WAIT_CYCLES=0 instance.
        w_rdata = 32'h1357_9BDF;
        w_m0_addr = 32'h0000_0040;
        w_m0_req = 1'b1;
        tick();
        w_m0_req = 1'b0;
        busy_cycles = (w_busy === 1'b1) ? 1 : 0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            exp_ack = (n == 2);
            exp_busy = (n == 1);
            if (w_busy === 1'b1) busy_cycles++;
            checks++;
            if (w_m0_ack !== exp_ack || w_busy !== exp_busy) begin
                errors++;
                $display("[TB] FAIL withdraw_w0_%0d: got ack=%b busy=%b expected %b/%b", n, w_m0_ack, w_busy, exp_ack, exp_busy);
            end
            if (n == 2) begin
                checks++;
                if (w_m0_rdata !== 32'h1357_9BDF) begin
                    errors++;
                    $display("[TB] FAIL withdraw_w0_rdata: got %h expected 13579bdf", w_m0_rdata);
                end
            end
        end
        checks++;
        if (busy_cycles != 2) begin
            errors++;
            $display("[TB] FAIL w0_busy_len: got %0d expected 2", busy_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        w_rdata = 32'h0F0F_0F0F;
        w_m1_addr = 32'h0000_0008;
        w_m1_wdata = 32'hCAFE_F00D;
        w_m1_wen = 1'b1;
        w_m1_req = 1'b1;
        tick();
        checks++;
        if (w_bus_wen !== 1'b1 || w_bus_addr !== 32'h0000_0008 || w_bus_wdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("[TB] FAIL w0_write: got wen=%b addr=%h data=%h expected 1/00000008/cafef00d", w_bus_wen, w_bus_addr, w_bus_wdata);
        end
        for (int n = 1; n <= 3; n++) begin
            tick();
            exp_ack = (n == 2);
            checks++;
            if (w_bus_wen !== 1'b0 || w_m1_ack !== exp_ack || w_m0_ack !== 1'b0) begin
                errors++;
                $display("[TB] FAIL w0_write%0d: got wen=%b m1_ack=%b m0_ack=%b expected 0/%b/0", n, w_bus_wen, w_m1_ack, w_m0_ack, exp_ack);
            end
            if (n == 2) begin
                checks++;
                if (w_m1_rdata !== 32'h0F0F_0F0F) begin
                    errors++;
                    $display("[TB] FAIL w0_write_rdata: got %h expected 0f0f0f0f", w_m1_rdata);
                end
                w_m1_req = 1'b0;
                w_m1_wen = 1'b0;
            end
        end
    endtask

    initial begin
        $display("[TB] starting bus_arbiter bench");
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_payload_change();
        test_reset_mid_busy();
        test_req_withdrawn();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter that shares the single-cycle CPU's data bus to the Bridge between the CPU load/store port (m0) and a second master (m1, DMA/debug loader).
- Each master uses a req/ack handshake. The arbiter serialises accesses and holds each access on the Bridge for a programmable slave latency.
- It returns read data and pulses ack when the access completes. The CPU's stall logic uses ack and busy to freeze its PC.

Parameters:
- WAIT_CYCLES, 1, number of extra cycles the Bridge needs before Bus_rdata is valid. Range 0..15.

Ports:
- cpu_clk  in  1  system clock; all state changes on rising edge.
- cpu_rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  CPU requests an access; held until m0_ack.
- m0_addr  in  32  CPU byte address.
- m0_wen  in  1  1 = write, 0 = read.
- m0_wdata  in  32  CPU write data.
- m0_ack  out  1  one-cycle completion pulse to CPU.
- m0_rdata  out  32  read data; valid while m0_ack is high.
- m1_req, m1_addr, m1_wen, m1_wdata, m1_ack, m1_rdata: same as the m0 set, for master 1.
- Bus_addr  out  32  address to Bridge.
- Bus_wen  out  1  write strobe to Bridge.
- Bus_wdata  out  32  write data to Bridge.
- Bus_rdata  in  32  read data from Bridge.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, cpu_rst_n=0):
  - FSM=IDLE, counter=0, last_gnt=1 (so m0 wins first contention).
  - All outputs 0: Bus_addr, Bus_wdata, Bus_wen, m0/m1_ack, m0/m1_rdata, busy.
  - Reset mid-transaction aborts it with no ack. Release is sampled on the next rising edge.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If no req, stay in IDLE; bus outputs hold their last values and Bus_wen=0.
  - If exactly one req is high, grant that master.
  - If both are high, grant the master that is not last_gnt (round-robin).
  - On grant: latch the granted addr/wen/wdata into the Bus_addr/Bus_wdata registers, record sel, load counter=WAIT_CYCLES, go to BUSY.
- BUSY:
  - Bus_wen = latched wen during the first BUSY cycle only (single write strobe), 0 otherwise.
  - If counter != 0: decrement the counter and stay in BUSY.
  - If counter == 0: capture Bus_rdata into the selected master's rdata register, go to RESP.
  - A write also captures Bus_rdata (don't-care value). The other master's rdata is unchanged.
- RESP:
  - Selected master's ack = 1 for exactly one cycle. last_gnt <= sel. Go to IDLE.
  - New requests are not sampled in RESP, so there is at least one IDLE cycle between transactions.
- Latency: req sampled in IDLE at edge k -> ack high in the cycle after edge k+WAIT_CYCLES+2. With WAIT_CYCLES=1, ack arrives 3 edges after the sampling edge.
- Throughput: one transaction per WAIT_CYCLES+3 cycles. Under continuous contention, grants strictly alternate m0,m1,m0,...
- Handshake rules:
  - A master must hold req and its payload stable until its ack.
  - Payload changes after grant are ignored, because the payload is latched.
  - If req drops mid-transaction, the transaction still completes and ack is still pulsed.
  - If req is still high in the IDLE cycle after ack, it is a new request.
- m0_ack and m1_ack are never high in the same cycle.
- busy = (state != IDLE).
- The counter is 4 bits. WAIT_CYCLES=0 goes straight from the single BUSY cycle to RESP.
- No address decode: all accesses go to the Bridge unchanged. Data widths pass through unmodified.

Test Plan:
- Reset: cpu_rst_n=0 asserted mid-BUSY with m0 write pending -> all outputs 0 immediately (asynchronously), no ack after release, FSM in IDLE; first request after release is served normally.
- Single read, WAIT_CYCLES=1: m0_req=1, m0_addr=0x0000_4000, m0_wen=0, Bridge returns 0xDEAD_BEEF -> Bus_addr=0x4000 from the cycle after sampling, Bus_wen never 1, m0_ack one cycle at sample edge+3, m0_rdata=0xDEAD_BEEF, m1_rdata unchanged.
- Single write: m1 writes 0x1234_5678 to 0xFFFF_F000 -> Bus_wen high exactly 1 cycle with Bus_wdata=0x1234_5678 and Bus_addr=0xFFFF_F000; m1_ack one pulse; m0_ack stays 0.
- Contention after reset: m0_req and m1_req rise together and both stay high for 4 transactions -> grant order m0,m1,m0,m1; ack pulses never overlap; each transaction is WAIT_CYCLES+3 cycles apart.
- Payload change after grant: m0 changes m0_addr 0x10 -> 0x20 during BUSY -> Bus_addr stays 0x10 until the next grant.
- Req withdrawn / WAIT_CYCLES=0: m0_req pulses high for 1 cycle -> transaction completes with m0_ack at edge+2; with WAIT_CYCLES=0, busy is high for exactly 2 cycles per access.
